fpu_addlane_scheduler: RTL and testbench

- Shares the single exponent-matching / addition lane of the half-precision FPU between two requesters.
  - Requester 0: standalone FADD/FSUB path.
  - Requester 1: FMADD path, which delivers the product mantissa already in the 2*man+4-bit format.
- Arbitrates requests, registers the winning operand set into the lane, and tracks in-flight tags through the lane's fixed latency.
- Steers each returning lane result to the correct requester and flags illegal opcodes.

---
 rtl/fpu_pkg.sv | 11 +
 rtl/fpu_tag_pipe.sv | 31 +++
 rtl/fpu_addlane_scheduler.sv | 128 ++++++++++++
 tb/tb_fpu_addlane_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, opcode encodings and the in-flight tag type for the FP16 add lane
package fpu_pkg;
    localparam int MAN_W = 2 * 9 + 4;
    localparam int EXP_W = 4 + 1;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/fpu_tag_pipe.sv
// fpu_tag_pipe: LAT-deep shift register of requester tags that tracks the lane latency
module fpu_tag_pipe
    import fpu_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_l,
    input  logic en,
    input  tag_t din,
    output tag_t dout,
    output logic any_valid
);
    tag_t pipe [LAT];

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid = any_valid | pipe[i].valid;
    end

    assign dout = pipe[LAT-1];
endmodule

// File: rtl/fpu_addlane_scheduler.sv
// fpu_addlane_scheduler: arbitrates FADD/FSUB and FMADD requesters onto the shared add lane and steers results back
module fpu_addlane_scheduler
    import fpu_pkg::*;
#(
    parameter int man = 9,
    parameter int exp = 4,
    parameter int LAT = 3,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              lane_en,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_sign_a,
    input  logic              r0_sign_b,
    input  logic [exp:0]      r0_exp_a,
    input  logic [exp:0]      r0_exp_b,
    input  logic [2*man+3:0]  r0_man_a,
    input  logic [2*man+3:0]  r0_man_b,
    input  logic [1:0]        r0_opcode,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_sign_a,
    input  logic              r1_sign_b,
    input  logic [exp:0]      r1_exp_a,
    input  logic [exp:0]      r1_exp_b,
    input  logic [2*man+3:0]  r1_man_a,
    input  logic [2*man+3:0]  r1_man_b,
    input  logic [1:0]        r1_opcode,
    output logic              lane_valid,
    output logic              lane_sign_a,
    output logic              lane_sign_b,
    output logic [exp:0]      lane_exp_a,
    output logic [exp:0]      lane_exp_b,
    output logic [2*man+3:0]  lane_man_a,
    output logic [2*man+3:0]  lane_man_b,
    output logic [1:0]        lane_opcode,
    input  logic              lane_res_sign,
    input  logic [exp:0]      lane_res_exp,
    input  logic [2*man+3:0]  lane_res_man,
    input  logic [2:0]        lane_res_grs,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic              rsp_sign,
    output logic [exp:0]      rsp_exp,
    output logic [2*man+3:0]  rsp_man,
    output logic [2:0]        rsp_grs,
    output logic              err0,
    output logic              err1,
    output logic              busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          grant0, grant1, legal_op, issue, tags_busy;
    logic [1:0]    win_op;
    tag_t          tail;

    // r1 normally wins a tie; r0 is forced through once it has lost STARVE_MAX times in a row
    always_comb begin
        grant1   = r1_valid & ~(r0_valid & (starve_cnt == SW'(STARVE_MAX)));
        grant0   = r0_valid & ~grant1;
        r0_ready = rst_l & lane_en & grant0;
        r1_ready = rst_l & lane_en & grant1;
        win_op   = grant1 ? r1_opcode : r0_opcode;
        legal_op = (win_op == OP_ADD) | (win_op == OP_SUB);
        issue    = (grant0 | grant1) & legal_op;
        busy     = lane_valid | tags_busy | rsp0_valid | rsp1_valid;
    end

    fpu_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk       (clk),
        .rst_l     (rst_l),
        .en        (lane_en),
        .din       ('{valid: issue, id: grant1}),
        .dout      (tail),
        .any_valid (tags_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            starve_cnt  <= '0;
            lane_valid  <= 1'b0;
            lane_sign_a <= 1'b0;
            lane_sign_b <= 1'b0;
            lane_exp_a  <= '0;
            lane_exp_b  <= '0;
            lane_man_a  <= '0;
            lane_man_b  <= '0;
            lane_opcode <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_sign    <= 1'b0;
            rsp_exp     <= '0;
            rsp_man     <= '0;
            rsp_grs     <= '0;
            err0        <= 1'b0;
            err1        <= 1'b0;
        end else begin
            // ready already folds in lane_en, so a stall can never raise an error pulse
            err0       <= r0_ready & ~legal_op;
            err1       <= r1_ready & ~legal_op;
            rsp0_valid <= lane_en & tail.valid & ~tail.id;
            rsp1_valid <= lane_en & tail.valid & tail.id;
            if (lane_en) begin
                starve_cnt <= (r0_valid & ~grant0)
                    ? ((starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1) : '0;
                lane_valid <= issue;
                if (issue) begin
                    lane_sign_a <= grant1 ? r1_sign_a : r0_sign_a;
                    lane_sign_b <= grant1 ? r1_sign_b : r0_sign_b;
                    lane_exp_a  <= grant1 ? r1_exp_a  : r0_exp_a;
                    lane_exp_b  <= grant1 ? r1_exp_b  : r0_exp_b;
                    lane_man_a  <= grant1 ? r1_man_a  : r0_man_a;
                    lane_man_b  <= grant1 ? r1_man_b  : r0_man_b;
                    lane_opcode <= win_op;
                end
                if (tail.valid) begin
                    rsp_sign <= lane_res_sign;
                    rsp_exp  <= lane_res_exp;
                    rsp_man  <= lane_res_man;
                    rsp_grs  <= lane_res_grs;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_addlane_scheduler.sv
// tb_fpu_addlane_scheduler: per-cycle vector table for arbitration/latency plus hand sequences for stall and reset
module tb_fpu_addlane_scheduler;
    import fpu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_l, lane_en;
    logic             r0_valid, r0_ready, r1_valid, r1_ready;
    logic             r0_sign_a, r0_sign_b, r1_sign_a, r1_sign_b;
    logic [EXP_W-1:0] r0_exp_a, r0_exp_b, r1_exp_a, r1_exp_b;
    logic [MAN_W-1:0] r0_man_a, r0_man_b, r1_man_a, r1_man_b;
    logic [1:0]       r0_opcode, r1_opcode;
    logic             lane_valid, lane_sign_a, lane_sign_b;
    logic [EXP_W-1:0] lane_exp_a, lane_exp_b;
    logic [MAN_W-1:0] lane_man_a, lane_man_b;
    logic [1:0]       lane_opcode;
    logic             lane_res_sign;
    logic [EXP_W-1:0] lane_res_exp;
    logic [MAN_W-1:0] lane_res_man;
    logic [2:0]       lane_res_grs;
    logic             rsp0_valid, rsp1_valid, rsp_sign;
    logic [EXP_W-1:0] rsp_exp;
    logic [MAN_W-1:0] rsp_man;
    logic [2:0]       rsp_grs;
    logic             err0, err1, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_addlane_scheduler #(.man(9), .exp(4), .LAT(3), .STARVE_MAX(3)) dut (
        .clk(clk), .rst_l(rst_l), .lane_en(lane_en),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_sign_a(r0_sign_a), .r0_sign_b(r0_sign_b),
        .r0_exp_a(r0_exp_a), .r0_exp_b(r0_exp_b), .r0_man_a(r0_man_a), .r0_man_b(r0_man_b),
        .r0_opcode(r0_opcode),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_sign_a(r1_sign_a), .r1_sign_b(r1_sign_b),
        .r1_exp_a(r1_exp_a), .r1_exp_b(r1_exp_b), .r1_man_a(r1_man_a), .r1_man_b(r1_man_b),
        .r1_opcode(r1_opcode),
        .lane_valid(lane_valid), .lane_sign_a(lane_sign_a), .lane_sign_b(lane_sign_b),
        .lane_exp_a(lane_exp_a), .lane_exp_b(lane_exp_b), .lane_man_a(lane_man_a),
        .lane_man_b(lane_man_b), .lane_opcode(lane_opcode),
        .lane_res_sign(lane_res_sign), .lane_res_exp(lane_res_exp), .lane_res_man(lane_res_man),
        .lane_res_grs(lane_res_grs),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_sign(rsp_sign), .rsp_exp(rsp_exp),
        .rsp_man(rsp_man), .rsp_grs(rsp_grs), .err0(err0), .err1(err1), .busy(busy)
    );

    // stim: r0_valid, r0_opcode, r1_valid, r1_opcode
    // want: r0_ready, r1_ready, lane_valid, lane_opcode, rsp0_valid, rsp1_valid, err0, err1, busy
    typedef struct {
        logic [5:0] stim;
        logic [9:0] want;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] obs();
        return {r0_ready, r1_ready, lane_valid, lane_opcode, rsp0_valid, rsp1_valid, err0, err1, busy};
    endfunction

    initial begin
        // single r0 add, LAT = 3
        tbl.push_back('{6'b1_01_0_00, 10'b1_0_0_00_0_0_0_0_0});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_1_01_0_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_0_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_0_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_1_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_0_0_0_0_0});
        // illegal r1 opcode: consumed, err1 next cycle, never issued or answered
        tbl.push_back('{6'b0_00_1_11, 10'b0_1_0_01_0_0_0_0_0});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_0_0_0_1_0});
        for (int i = 0; i < 4; i++) tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_0_0_0_0_0});
        // r0 alone for 5 cycles
        tbl.push_back('{6'b1_01_0_00, 10'b1_0_0_01_0_0_0_0_0});
        for (int i = 0; i < 3; i++) tbl.push_back('{6'b1_01_0_00, 10'b1_0_1_01_0_0_0_0_1});
        tbl.push_back('{6'b1_01_0_00, 10'b1_0_1_01_1_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_1_01_1_0_0_0_1});
        for (int i = 0; i < 3; i++) tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_1_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_01_0_0_0_0_0});
        // both valid for 10 cycles: r1 r1 r1 r0 r1 r1 r1 r0 r1 r1
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_0_01_0_0_0_0_0});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_10_0_0_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_10_0_0_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b1_0_1_10_0_0_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_01_0_1_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_10_0_1_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_10_0_1_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b1_0_1_10_1_0_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_01_0_1_0_0_1});
        tbl.push_back('{6'b1_01_1_10, 10'b0_1_1_10_0_1_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_1_10_0_1_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_10_1_0_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_10_0_1_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_10_0_1_0_0_1});
        tbl.push_back('{6'b0_00_0_00, 10'b0_0_0_10_0_0_0_0_0});

        rst_l = 1'b0; lane_en = 1'b1;
        {r0_valid, r0_opcode, r1_valid, r1_opcode} = '0;
        r0_sign_a = 1'b0; r0_sign_b = 1'b1; r0_exp_a = 5'd15; r0_exp_b = 5'd12;
        r0_man_a = 22'h2A5A5; r0_man_b = 22'h01234;
        r1_sign_a = 1'b1; r1_sign_b = 1'b0; r1_exp_a = 5'd7; r1_exp_b = 5'd3;
        r1_man_a = 22'h3FFFF; r1_man_b = 22'h00111;
        lane_res_sign = 1'b1; lane_res_exp = 5'd9; lane_res_man = 22'h21357; lane_res_grs = 3'b101;
        tick; tick;
        #4 chk("reset_state", {obs(), rsp_exp, lane_man_a}, '0);
        rst_l = 1'b1;

        foreach (tbl[i]) begin
            tick;
            {r0_valid, r0_opcode, r1_valid, r1_opcode} = tbl[i].stim;
            #4 chk($sformatf("row%0d", i), obs(), tbl[i].want);
        end

        // issue at t, stall at t+2 and t+3: response slides from t+4 to t+6
        tick; r0_valid = 1'b1; r0_opcode = OP_ADD;
        #4 chk("stall_t_ready", r0_ready, 1'b1);
        tick; r0_valid = 1'b0;
        #4 chk("stall_lane_ops", {lane_valid, lane_sign_a, lane_sign_b, lane_exp_a, lane_exp_b,
                                  lane_man_a, lane_man_b},
               {1'b1, 1'b0, 1'b1, 5'd15, 5'd12, 22'h2A5A5, 22'h01234});
        for (int c = 2; c <= 3; c++) begin
            tick; lane_en = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1; r1_opcode = OP_SUB;
            #4 chk($sformatf("stall_c%0d", c), {r0_ready, r1_ready, rsp0_valid, rsp1_valid, err0, err1},
                   6'b0);
        end
        tick; lane_en = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        #4 chk("stall_t4", {rsp0_valid, rsp1_valid}, 2'b00);
        tick;
        #4 chk("stall_t5", {rsp0_valid, rsp1_valid, busy}, 3'b001);
        tick;
        #4 chk("stall_t6", {rsp0_valid, rsp1_valid, rsp_sign, rsp_exp, rsp_man, rsp_grs},
               {1'b1, 1'b0, 1'b1, 5'd9, 22'h21357, 3'b101});
        tick;
        #4 chk("stall_t7", {rsp0_valid, rsp1_valid, busy}, 3'b000);

        // two ops in flight, then a one-cycle reset discards them
        tick; r0_valid = 1'b1; r0_opcode = OP_ADD;
        tick; r0_valid = 1'b0; r1_valid = 1'b1; r1_opcode = OP_SUB;
        tick; rst_l = 1'b0;
        #4 chk("rst_ready", {r0_ready, r1_ready}, 2'b00);
        tick; rst_l = 1'b1; r1_valid = 1'b0;
        #4 chk("rst_after", {obs(), lane_exp_a, lane_man_a, rsp_sign, rsp_exp, rsp_man, rsp_grs}, '0);
        begin
            int pulses = 0;
            for (int c = 0; c < 6; c++) begin
                tick;
                #4 pulses += int'(rsp0_valid) + int'(rsp1_valid);
            end
            chk("rst_no_rsp", 64'(pulses), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
